// File: rtl/edge_cache_pkg.sv
// rtl/edge_cache_pkg.sv - shared types for edge_cache
package edge_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HIT   = 2'd3
    } ec_state_e;

endpackage

// File: rtl/constants.v
// rtl/constants.v - default parameters and floating-point constants for edge_cache
`ifndef EDGE_CACHE_CONSTANTS_V
`define EDGE_CACHE_CONSTANTS_V
`define DEFAULT_MAX_NODES   16
`define DEFAULT_INDEX_WIDTH 8
`define DEFAULT_VALUE_WIDTH 32
`define FP_INFINITY         32'h7F800000
`endif

// File: rtl/edge_row_buffer.sv
// rtl/edge_row_buffer.sv - single-row weight store, one write port, asynchronous read port
module edge_row_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Out-of-range addresses are dropped on write and read back as zero.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_addr < DEPTH_L)) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < DEPTH_L) ? mem_q[rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/edge_cache.sv
// rtl/edge_cache.sv - one-row adjacency-matrix cache fed by a pipelined Avalon-MM read master
`include "constants.v"

module edge_cache
    import edge_cache_pkg::*;
#(
    parameter int                    MAX_NODES    = `DEFAULT_MAX_NODES,
    parameter int                    INDEX_WIDTH  = `DEFAULT_INDEX_WIDTH,
    parameter int                    VALUE_WIDTH  = `DEFAULT_VALUE_WIDTH,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic                   ec_query,
    input  logic [INDEX_WIDTH-1:0] ec_from_node,
    input  logic [INDEX_WIDTH-1:0] ec_to_node,
    output logic                   ec_ready,
    output logic [VALUE_WIDTH-1:0] ec_edge_value,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic                   mem_read,
    input  logic                   mem_waitrequest,
    input  logic [VALUE_WIDTH-1:0] mem_readdata,
    input  logic                   mem_readdatavalid
);

    localparam int CW = INDEX_WIDTH + 1;
    localparam logic [CW-1:0] MAX_L = CW'(MAX_NODES);

    ec_state_e              state_q, state_d;
    logic                   row_valid_q, row_valid_d;
    logic [INDEX_WIDTH-1:0] loaded_row_q, loaded_row_d;
    logic [INDEX_WIDTH-1:0] fill_row_q, fill_row_d;
    logic [CW-1:0]          issue_count_q, issue_count_d;
    logic [CW-1:0]          recv_count_q, recv_count_d;

    logic [CW-1:0]          nodes_ext;
    logic [CW-1:0]          n_eff;
    logic                   filling;
    logic                   fill_done;
    logic                   row_hit;
    logic                   start_fill;
    logic                   resp_ok;
    logic [VALUE_WIDTH-1:0] buf_rd_data;

    assign nodes_ext = {1'b0, number_of_nodes};
    assign n_eff     = (nodes_ext > MAX_L) ? MAX_L : nodes_ext;
    assign filling   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign fill_done = filling && (issue_count_q == n_eff) && (recv_count_q == n_eff);
    assign row_hit   = row_valid_q && (ec_from_node == loaded_row_q);
    // Responses outside a fill (stray or left over from before a reset) never touch the buffer.
    assign resp_ok   = reset && filling && mem_readdatavalid && (recv_count_q < n_eff);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ec_query) begin
                    state_d = row_hit ? ST_HIT : ST_ISSUE;
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                if (fill_done) begin
                    if (!ec_query) begin
                        state_d = ST_IDLE;
                    end else if (ec_from_node == fill_row_q) begin
                        state_d = ST_HIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if ((state_q == ST_ISSUE) && (issue_count_q == n_eff)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HIT: begin
                if (!ec_query) begin
                    state_d = ST_IDLE;
                end else if (ec_from_node != loaded_row_q) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read    = (state_q == ST_ISSUE) && (issue_count_q < n_eff);
        mem_address = '0;
        if (state_q == ST_ISSUE) begin
            mem_address = BASE_ADDRESS
                        + ADDR_WIDTH'(fill_row_q) * ADDR_WIDTH'(MAX_NODES)
                        + ADDR_WIDTH'(issue_count_q);
        end
        ec_ready      = (state_q == ST_HIT) && ec_query && row_hit;
        ec_edge_value = ({1'b0, ec_to_node} >= n_eff) ? VALUE_WIDTH'(`FP_INFINITY) : buf_rd_data;
    end

    // A completing fill that immediately refills still records the finished row before invalidating it.
    assign start_fill = (state_d == ST_ISSUE) && ((state_q != ST_ISSUE) || fill_done);

    always_comb begin
        row_valid_d   = row_valid_q;
        loaded_row_d  = loaded_row_q;
        fill_row_d    = fill_row_q;
        issue_count_d = issue_count_q;
        recv_count_d  = recv_count_q;
        if (mem_read && !mem_waitrequest) begin
            issue_count_d = issue_count_q + 1'b1;
        end
        if (resp_ok) begin
            recv_count_d = recv_count_q + 1'b1;
        end
        if (fill_done) begin
            row_valid_d  = 1'b1;
            loaded_row_d = fill_row_q;
        end
        if (start_fill) begin
            fill_row_d    = ec_from_node;
            issue_count_d = '0;
            recv_count_d  = '0;
            row_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            row_valid_q   <= 1'b0;
            loaded_row_q  <= '0;
            fill_row_q    <= '0;
            issue_count_q <= '0;
            recv_count_q  <= '0;
        end else begin
            row_valid_q   <= row_valid_d;
            loaded_row_q  <= loaded_row_d;
            fill_row_q    <= fill_row_d;
            issue_count_q <= issue_count_d;
            recv_count_q  <= recv_count_d;
        end
    end

    edge_row_buffer #(
        .DEPTH  (MAX_NODES),
        .ADDR_W (CW),
        .DATA_W (VALUE_WIDTH)
    ) u_row_buffer (
        .clock   (clock),
        .wr_en   (resp_ok),
        .wr_addr (recv_count_q),
        .wr_data (mem_readdata),
        .rd_addr ({1'b0, ec_to_node}),
        .rd_data (buf_rd_data)
    );

endmodule

// File: tb/tb_edge_cache.sv
// tb/tb_edge_cache.sv - self-checking bench for edge_cache with an Avalon-MM memory model
module tb_edge_cache;

    localparam int MN = 4;
    localparam int IW = 4;
    localparam int VW = 32;
    localparam int AW = 16;
    localparam logic [31:0] INF = 32'h7F800000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [IW-1:0] number_of_nodes = 4'd4;
    logic          ec_query = 1'b0;
    logic [IW-1:0] ec_from_node = '0;
    logic [IW-1:0] ec_to_node = '0;
    logic          ec_ready;
    logic [VW-1:0] ec_edge_value;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_waitrequest = 1'b0;
    logic [VW-1:0] mem_readdata = '0;
    logic          mem_readdatavalid = 1'b0;

    edge_cache #(
        .MAX_NODES    (MN),
        .INDEX_WIDTH  (IW),
        .VALUE_WIDTH  (VW),
        .ADDR_WIDTH   (AW),
        .BASE_ADDRESS ('0)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .number_of_nodes   (number_of_nodes),
        .ec_query          (ec_query),
        .ec_from_node      (ec_from_node),
        .ec_to_node        (ec_to_node),
        .ec_ready          (ec_ready),
        .ec_edge_value     (ec_edge_value),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [64];
    int model_loaded = -1;

    // Memory slave: acts on falling edges so every DUT input is stable around the rising edge.
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;
    pend_t         pq[$];
    logic [AW-1:0] addr_log[$];
    int            cyc = 0;
    int            lat = 1;
    bit            wr_random = 0;
    int            stall_budget = 0;
    int            stall_taken = 0;
    int            total_reads = 0;

    always @(negedge clock) begin
        pend_t p;
        cyc = cyc + 1;
        mem_readdatavalid = 1'b0;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            mem_readdata      = model_mem[pq[0].addr[5:0]];
            mem_readdatavalid = 1'b1;
            void'(pq.pop_front());
        end
        if (mem_read && stall_taken < stall_budget) begin
            mem_waitrequest = 1'b1;
            stall_taken     = stall_taken + 1;
        end else begin
            mem_waitrequest = wr_random ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (mem_read && !mem_waitrequest) begin
            p.addr = mem_address;
            p.due  = cyc + lat;
            pq.push_back(p);
            addr_log.push_back(mem_address);
            total_reads = total_reads + 1;
        end
    end

    function automatic logic [31:0] exp_val(int from, int to, int n);
        if (to >= n) return INF;
        return model_mem[from * MN + to];
    endfunction

    task automatic wait_ready(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (ec_ready) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ec_query = 1'b0;
        number_of_nodes = 4'd4;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (ec_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ec_ready); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
        checks++; if (mem_address !== '0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        checks++; if (dut.row_valid_q !== 1'b0) begin errors++; $display("FAIL reset_row_valid: got %b expected 0", dut.row_valid_q); end
        checks++; if (dut.loaded_row_q !== '0) begin errors++; $display("FAIL reset_loaded_row: got %h expected 0", dut.loaded_row_q); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_first_fill();
        bit ok;
        int start;
        start = total_reads;
        @(negedge clock);
        ec_query = 1'b1; ec_from_node = 4'd2; ec_to_node = 4'd3;
        wait_ready(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL first_ready: got 0 expected 1 within 100 cycles"); end
        checks++; if (total_reads - start != 4) begin errors++; $display("FAIL first_read_count: got %0d expected 4", total_reads - start); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log.size() < start + i + 1 || addr_log[start + i] !== AW'(8 + i)) begin
                errors++; $display("FAIL first_addr[%0d]: got %h expected %h", i,
                    (addr_log.size() > start + i) ? addr_log[start + i] : 'x, AW'(8 + i));
            end
        end
        checks++; if (ec_edge_value !== 32'h3F000000) begin errors++; $display("FAIL first_value: got %h expected 3f000000", ec_edge_value); end
        model_loaded = 2;
    endtask

    task automatic test_hit_sweep();
        int start;
        logic [31:0] exp_row [4];
        exp_row[0] = 32'h3F800000; exp_row[1] = INF; exp_row[2] = 32'h40600000; exp_row[3] = 32'h3F000000;
        start = total_reads;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            ec_to_node = IW'(t);
            #1;
            checks++; if (ec_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready[%0d]: got %b expected 1", t, ec_ready); end
            checks++; if (ec_edge_value !== exp_row[t]) begin errors++; $display("FAIL sweep_value[%0d]: got %h expected %h", t, ec_edge_value, exp_row[t]); end
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL sweep_mem_read[%0d]: got %b expected 0", t, mem_read); end
        end
        checks++; if (total_reads != start) begin errors++; $display("FAIL sweep_reads: got %0d expected 0", total_reads - start); end
    endtask

    task automatic test_out_of_range();
        @(negedge clock);
        ec_to_node = 4'd6;
        #1;
        checks++; if (ec_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b expected 1", ec_ready); end
        checks++; if (ec_edge_value !== INF) begin errors++; $display("FAIL oor_value: got %h expected %h", ec_edge_value, INF); end
        @(negedge clock);
        number_of_nodes = 4'd9;
        ec_to_node = 4'd3;
        #1;
        checks++; if (ec_edge_value !== exp_val(2, 3, 4)) begin errors++; $display("FAIL clamp_in_value: got %h expected %h", ec_edge_value, exp_val(2, 3, 4)); end
        @(negedge clock);
        ec_to_node = 4'd4;
        #1;
        checks++; if (ec_edge_value !== INF) begin errors++; $display("FAIL clamp_out_value: got %h expected %h", ec_edge_value, INF); end
        number_of_nodes = 4'd4;
    endtask

    task automatic test_waitrequest();
        bit ok;
        int start;
        logic [AW-1:0] seen[$];
        @(negedge clock);
        ec_from_node = 4'd0; ec_to_node = 4'd1;
        wait_ready(100, ok);
        checks++; if (!ok || ec_edge_value !== exp_val(0, 1, 4)) begin errors++; $display("FAIL wr_row0: got ready %b value %h expected ready 1 value %h", ec_ready, ec_edge_value, exp_val(0, 1, 4)); end
        model_loaded = 0;
        start = total_reads;
        @(negedge clock);
        stall_budget = stall_taken + 3;
        ec_from_node = 4'd2; ec_to_node = 4'd1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (mem_read) seen.push_back(mem_address);
            if (ec_ready) begin ok = 1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL wr_ready: got 0 expected 1 within 100 cycles"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen.size() < i + 1 || seen[i] !== AW'(8)) begin
                errors++; $display("FAIL wr_hold_addr[%0d]: got %h expected 0008", i, (seen.size() > i) ? seen[i] : 'x);
            end
        end
        checks++; if (total_reads - start != 4) begin errors++; $display("FAIL wr_read_count: got %0d expected 4", total_reads - start); end
        checks++; if (ec_edge_value !== INF) begin errors++; $display("FAIL wr_value: got %h expected %h", ec_edge_value, INF); end
        model_loaded = 2;
    endtask

    task automatic test_refill_drain();
        bit ok;
        bit early;
        int start;
        @(negedge clock);
        ec_from_node = 4'd3; ec_to_node = 4'd0;
        wait_ready(100, ok);
        checks++; if (!ok || ec_edge_value !== exp_val(3, 0, 4)) begin errors++; $display("FAIL rd_row3: got ready %b value %h expected ready 1 value %h", ec_ready, ec_edge_value, exp_val(3, 0, 4)); end
        lat = 4;
        start = total_reads;
        early = 0;
        @(negedge clock);
        ec_from_node = 4'd2; ec_to_node = 4'd2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (ec_ready) early = 1;
            if (total_reads - start >= 4) break;
        end
        ec_from_node = 4'd1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock); #1;
            if (ec_ready) begin
                ok = 1;
                if (total_reads - start < 8) early = 1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rd_ready: got 0 expected 1 within 200 cycles"); end
        checks++; if (early) begin errors++; $display("FAIL rd_early_ready: got ready before row 1 loaded expected none"); end
        checks++; if (total_reads - start != 8) begin errors++; $display("FAIL rd_read_count: got %0d expected 8", total_reads - start); end
        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] ea;
            ea = (i < 4) ? AW'(8 + i) : AW'(i);
            checks++;
            if (addr_log.size() < start + i + 1 || addr_log[start + i] !== ea) begin
                errors++; $display("FAIL rd_addr[%0d]: got %h expected %h", i,
                    (addr_log.size() > start + i) ? addr_log[start + i] : 'x, ea);
            end
        end
        checks++; if (ec_edge_value !== exp_val(1, 2, 4)) begin errors++; $display("FAIL rd_value: got %h expected %h", ec_edge_value, exp_val(1, 2, 4)); end
        lat = 1;
        model_loaded = 1;
    endtask

    task automatic test_random();
        bit ok;
        int start, from, to, exp_reads;
        wr_random = 1;
        for (int it = 0; it < 30; it++) begin
            from = $urandom_range(0, 3);
            to   = $urandom_range(0, 7);
            lat  = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clock);
                ec_query = 1'b0;
            end
            exp_reads = (from == model_loaded) ? 0 : 4;
            start = total_reads;
            @(negedge clock);
            ec_query = 1'b1;
            ec_from_node = IW'(from);
            ec_to_node = IW'(to);
            number_of_nodes = IW'($urandom_range(4, 15));
            wait_ready(300, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd_ready[%0d]: got 0 expected 1", it); end
            checks++; if (ec_edge_value !== exp_val(from, to, 4)) begin errors++; $display("FAIL rnd_value[%0d]: got %h expected %h", it, ec_edge_value, exp_val(from, to, 4)); end
            checks++; if (total_reads - start != exp_reads) begin errors++; $display("FAIL rnd_reads[%0d]: got %0d expected %0d", it, total_reads - start, exp_reads); end
            model_loaded = from;
            to = $urandom_range(0, 7);
            @(negedge clock);
            ec_to_node = IW'(to);
            #1;
            checks++; if (ec_ready !== 1'b1 || ec_edge_value !== exp_val(from, to, 4)) begin errors++; $display("FAIL rnd_to[%0d]: got ready %b value %h expected ready 1 value %h", it, ec_ready, ec_edge_value, exp_val(from, to, 4)); end
        end
        wr_random = 0;
        lat = 1;
        number_of_nodes = 4'd4;
    endtask

    task automatic test_n_zero();
        int start, from;
        from = (model_loaded + 1) % 4;
        start = total_reads;
        @(negedge clock);
        number_of_nodes = 4'd0;
        ec_query = 1'b1; ec_from_node = IW'(from); ec_to_node = 4'd0;
        @(negedge clock); #1;
        checks++; if (ec_ready !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL n0_issue: got ready %b mem_read %b expected 0 0", ec_ready, mem_read); end
        checks++; if (dut.row_valid_q !== 1'b0) begin errors++; $display("FAIL n0_row_invalid: got %b expected 0", dut.row_valid_q); end
        @(negedge clock); #1;
        checks++; if (dut.row_valid_q !== 1'b1) begin errors++; $display("FAIL n0_row_valid: got %b expected 1", dut.row_valid_q); end
        checks++; if (ec_ready !== 1'b1 || ec_edge_value !== INF) begin errors++; $display("FAIL n0_ready: got ready %b value %h expected ready 1 value %h", ec_ready, ec_edge_value, INF); end
        checks++; if (total_reads != start) begin errors++; $display("FAIL n0_reads: got %0d expected 0", total_reads - start); end
        number_of_nodes = 4'd4;
        model_loaded = -1;
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        bit stray;
        int start;
        @(negedge clock);
        ec_query = 1'b0;
        @(negedge clock);
        lat = 8;
        start = total_reads;
        ec_query = 1'b1; ec_from_node = 4'd3; ec_to_node = 4'd1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock); #1;
            if (total_reads - start >= 2) break;
        end
        reset = 1'b0;
        ec_query = 1'b0;
        @(negedge clock); #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_read: got %b expected 0", mem_read); end
        checks++; if (ec_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", ec_ready); end
        checks++; if (dut.row_valid_q !== 1'b0) begin errors++; $display("FAIL rst_mid_row_valid: got %b expected 0", dut.row_valid_q); end
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 50 && pq.size() > 0; i++) begin
            @(negedge clock); #1;
            if (ec_ready || mem_read) stray = 1;
        end
        @(negedge clock); #1;
        checks++; if (stray || pq.size() != 0) begin errors++; $display("FAIL rst_late_resp: got stray %b pending %0d expected 0 0", stray, pq.size()); end
        lat = 1;
        start = total_reads;
        @(negedge clock);
        ec_query = 1'b1; ec_from_node = 4'd3; ec_to_node = 4'd1;
        wait_ready(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_refill_ready: got 0 expected 1"); end
        checks++; if (total_reads - start != 4) begin errors++; $display("FAIL rst_refill_reads: got %0d expected 4", total_reads - start); end
        checks++; if (ec_edge_value !== exp_val(3, 1, 4)) begin errors++; $display("FAIL rst_refill_value: got %h expected %h", ec_edge_value, exp_val(3, 1, 4)); end
        model_loaded = 3;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = $urandom;
        model_mem[8]  = 32'h3F800000;
        model_mem[9]  = INF;
        model_mem[10] = 32'h40600000;
        model_mem[11] = 32'h3F000000;
        test_reset();
        test_first_fill();
        test_hit_sweep();
        test_out_of_range();
        test_waitrequest();
        test_refill_drain();
        test_random();
        test_n_zero();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
